// File: rtl/fifo_sel_arb_if.sv
// Bundle of request/grant signals between the FIFO flag side and the arbiter.
//
// Grant protocol: fifo_sel_res_final[7] is the grant valid bit. The consumer
// acknowledges with a one-cycle sel_done pulse, sampled at the clock edge.
// A grant also ends if its request bit drops or its hold time runs out.
// After any release there is at least one cycle with the result at 8'd0.
// state_dbg mirrors the arbiter FSM (0 = idle, 1 = holding a grant).
interface fifo_sel_arb_if #(
  parameter int PORT_NUM = 10
);
  logic [PORT_NUM-1:0] fifo_sel_bits;
  logic                rr_mode;
  logic                sel_done;
  logic [7:0]          fifo_sel_res_final;
  logic [PORT_NUM-1:0] fifo_grant_onehot;
  logic                sel_timeout;
  logic                state_dbg;

  modport master (
    output fifo_sel_bits, rr_mode, sel_done,
    input  fifo_sel_res_final, fifo_grant_onehot, sel_timeout, state_dbg
  );

  modport slave (
    input  fifo_sel_bits, rr_mode, sel_done,
    output fifo_sel_res_final, fifo_grant_onehot, sel_timeout, state_dbg
  );
endinterface

// File: rtl/fifo_sel_arb.sv
// FIFO-select arbiter: grants one requesting port (fixed priority or
// round-robin) and holds that grant until done, request drop or timeout.
module fifo_sel_arb #(
  parameter int PORT_NUM = 10,
  parameter int IDX_W    = 7,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic           glb_clk,
  input logic           glb_areset_n,
  fifo_sel_arb_if.slave arb
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    cur_idx;
  logic [IDX_W-1:0]    last_grant;
  logic [CNT_W-1:0]    hold_cnt;

  logic [PORT_NUM-1:0] hi_mask;
  logic [PORT_NUM-1:0] hi_req;
  logic [PORT_NUM-1:0] pick_vec;
  logic [IDX_W-1:0]    win_idx;
  logic [PORT_NUM-1:0] win_oh;
  logic                rel_user;
  logic                rel_tout;

  assign arb.state_dbg = (state == ST_HOLD);

  // Ports strictly above the last grant; these win a round-robin scan first.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      hi_mask[i] = (i > int'(last_grant));
    end
  end

  assign hi_req = arb.fifo_sel_bits & hi_mask;

  // Winner = lowest set bit of the upper slice (round-robin) or of all requests.
  always_comb begin
    pick_vec = (arb.rr_mode && (|hi_req)) ? hi_req : arb.fifo_sel_bits;
    win_idx  = '0;
    win_oh   = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_idx    = IDX_W'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
  end

  // The registered one-hot grant doubles as the mask for the held request bit.
  assign rel_user = arb.sel_done | ~(|(arb.fifo_sel_bits & arb.fifo_grant_onehot));
  assign rel_tout = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state                  <= ST_IDLE;
      cur_idx                <= '0;
      last_grant             <= IDX_W'(PORT_NUM - 1);
      hold_cnt               <= '0;
      arb.fifo_sel_res_final <= 8'd0;
      arb.fifo_grant_onehot  <= '0;
      arb.sel_timeout        <= 1'b0;
    end else begin
      arb.sel_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|arb.fifo_sel_bits) begin
            state                  <= ST_HOLD;
            cur_idx                <= win_idx;
            hold_cnt               <= '0;
            arb.fifo_sel_res_final <= {1'b1, 7'(win_idx)};
            arb.fifo_grant_onehot  <= win_oh;
          end
        end
        ST_HOLD: begin
          if (rel_user || rel_tout) begin
            state                  <= ST_IDLE;
            last_grant             <= cur_idx;
            arb.fifo_sel_res_final <= 8'd0;
            arb.fifo_grant_onehot  <= '0;
            arb.sel_timeout        <= rel_tout && !rel_user;
          end else if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sel_arb.sv
// Bench for fifo_sel_arb: directed scenarios plus random traffic, checked
// against a cycle-level reference model of the grant rules.
module tb_fifo_sel_arb;
  localparam int N  = 10;
  localparam int MH = 16;

  // ---------------- clock / reset ----------------
  logic glb_clk = 1'b0;
  logic glb_areset_n;
  always #5 glb_clk = ~glb_clk;

  fifo_sel_arb_if #(.PORT_NUM(N)) arb_if ();

  fifo_sel_arb #(
    .PORT_NUM(N), .IDX_W(7), .MAX_HOLD(MH), .CNT_W(8)
  ) dut (
    .glb_clk     (glb_clk),
    .glb_areset_n(glb_areset_n),
    .arb         (arb_if.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];   // {timeout, onehot[9:0], result[7:0]}

  // Reference model: granted port (-1 = none), cycles granted, last granted port.
  int   m_cur;
  int   m_len;
  int   m_last;
  logic m_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cur  = -1;
    m_len  = 0;
    m_last = N - 1;
    m_to   = 1'b0;
    exp_q.delete();
  endfunction

  task automatic model_step(input logic [N-1:0] bits, input logic rr, input logic done);
    logic [N-1:0] oh;
    logic [7:0]   res;
    int           w;
    bit           user_rel;
    bit           tout_rel;
    if (m_cur < 0) begin
      m_to = 1'b0;
      if (bits != '0) begin
        w = -1;
        if (rr) begin
          for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (w < 0 && bits[p]) w = p;
          end
        end else begin
          for (int p = 0; p < N; p++) if (w < 0 && bits[p]) w = p;
        end
        m_cur = w;
        m_len = 1;
      end
    end else begin
      user_rel = done || !bits[m_cur];
      tout_rel = (MH != 0) && (m_len == MH);
      if (user_rel || tout_rel) begin
        m_to   = !user_rel;
        m_last = m_cur;
        m_cur  = -1;
      end else begin
        m_len++;
        m_to = 1'b0;
      end
    end
    oh  = (m_cur < 0) ? '0 : (N'(1) << m_cur);
    res = (m_cur < 0) ? 8'd0 : 8'(128 + m_cur);
    exp_q.push_back({m_to, oh, res});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive inputs, let one posedge pass, check, return at next negedge.
  task automatic step(input logic [N-1:0] bits, input logic rr, input logic done);
    logic [18:0] e;
    arb_if.fifo_sel_bits = bits;
    arb_if.rr_mode       = rr;
    arb_if.sel_done      = done;
    @(posedge glb_clk);
    model_step(bits, rr, done);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("sb_res",     32'(arb_if.fifo_sel_res_final), 32'(e[7:0]));
      check_val("sb_onehot",  32'(arb_if.fifo_grant_onehot),  32'(e[17:8]));
      check_val("sb_timeout", 32'(arb_if.sel_timeout),        32'(e[18]));
    end
    @(negedge glb_clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_res"},    32'(arb_if.fifo_sel_res_final), 32'd0);
    check_val({tag, "_onehot"}, 32'(arb_if.fifo_grant_onehot),  32'd0);
    check_val({tag, "_tout"},   32'(arb_if.sel_timeout),        32'd0);
  endtask

  task automatic do_reset();
    glb_areset_n         = 1'b0;
    arb_if.fifo_sel_bits = '0;
    model_reset();
    #1;
    check_idle_outputs("rst");
    @(negedge glb_clk);
    glb_areset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] rbits;
    glb_areset_n         = 1'b0;
    arb_if.fifo_sel_bits = 10'h3FF;
    arb_if.rr_mode       = 1'b0;
    arb_if.sel_done      = 1'b0;
    model_reset();

    // Reset with all requests high, then first grant
    @(negedge glb_clk);
    check_idle_outputs("por");
    glb_areset_n = 1'b1;
    step(10'h3FF, 1'b0, 1'b0);
    check_val("por_first_grant", 32'(arb_if.fifo_sel_res_final), 32'h80);
    step(10'h000, 1'b0, 1'b0);
    step(10'h000, 1'b0, 1'b0);

    // Fixed priority and hold
    step(10'h004, 1'b0, 1'b0);
    check_val("fp_grant2", 32'(arb_if.fifo_sel_res_final), 32'h82);
    step(10'h005, 1'b0, 1'b0);
    check_val("fp_hold2", 32'(arb_if.fifo_sel_res_final), 32'h82);
    step(10'h001, 1'b0, 1'b0);
    check_val("fp_gap", 32'(arb_if.fifo_sel_res_final), 32'h00);
    step(10'h001, 1'b0, 1'b0);
    check_val("fp_grant0", 32'(arb_if.fifo_sel_res_final), 32'h80);
    step(10'h000, 1'b0, 1'b0);

    // Round-robin rotation with wrap
    do_reset();
    for (int k = 0; k < 11; k++) begin
      step(10'h3FF, 1'b1, 1'b0);
      check_val("rr_grant", 32'(arb_if.fifo_sel_res_final), 32'(8'h80 + (k % N)));
      step(10'h3FF, 1'b1, 1'b1);
      check_val("rr_gap", 32'(arb_if.fifo_sel_res_final), 32'h00);
    end
    step(10'h000, 1'b1, 1'b0);

    // Timeout after exactly MH cycles, then regrant
    for (int k = 0; k < MH; k++) begin
      step(10'h020, 1'b0, 1'b0);
      check_val("to_hold", 32'(arb_if.fifo_sel_res_final), 32'h85);
    end
    step(10'h020, 1'b0, 1'b0);
    check_val("to_gap", 32'(arb_if.fifo_sel_res_final), 32'h00);
    check_val("to_pulse", 32'(arb_if.sel_timeout), 32'd1);
    step(10'h020, 1'b0, 1'b0);
    check_val("to_regrant", 32'(arb_if.fifo_sel_res_final), 32'h85);
    check_val("to_pulse_end", 32'(arb_if.sel_timeout), 32'd0);
    step(10'h000, 1'b0, 1'b0);

    // sel_done on the final hold cycle: normal release
    step(10'h020, 1'b0, 1'b0);
    for (int k = 0; k < MH - 1; k++) step(10'h020, 1'b0, 1'b0);
    step(10'h020, 1'b0, 1'b1);
    check_val("sim_done_res", 32'(arb_if.fifo_sel_res_final), 32'h00);
    check_val("sim_done_tout", 32'(arb_if.sel_timeout), 32'd0);
    step(10'h000, 1'b0, 1'b0);

    // sel_done together with request drop: single gap
    step(10'h060, 1'b0, 1'b0);
    check_val("drop_grant", 32'(arb_if.fifo_sel_res_final), 32'h85);
    step(10'h040, 1'b0, 1'b1);
    check_val("drop_gap", 32'(arb_if.fifo_sel_res_final), 32'h00);
    step(10'h040, 1'b0, 1'b0);
    check_val("drop_next", 32'(arb_if.fifo_sel_res_final), 32'h86);
    step(10'h000, 1'b0, 1'b0);

    // Reset in the middle of a round-robin grant
    do_reset();
    step(10'h008, 1'b1, 1'b0);
    check_val("mid_grant", 32'(arb_if.fifo_sel_res_final), 32'h83);
    #2;
    glb_areset_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    model_reset();
    arb_if.fifo_sel_bits = '0;
    @(negedge glb_clk);
    glb_areset_n = 1'b1;
    step(10'h00C, 1'b1, 1'b0);
    check_val("mid_restart", 32'(arb_if.fifo_sel_res_final), 32'h82);

    // Random traffic: slowly changing requests so timeouts also occur
    rbits = 10'($urandom());
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        rbits = ($urandom_range(0, 3) == 0) ? '0 : 10'($urandom());
      end
      step(rbits, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sel_arb.md
# fifo_sel_arb

Parametrised FIFO-select arbiter, next generation of the fixed 10-port priority selector. It picks one of PORT_NUM requesting FIFOs and holds that grant until the consumer releases it, the request drops, or a hold timeout expires. It supports fixed-priority and round-robin modes. It sits between the per-port FIFO non-empty flags and the shared output mux/reader, and keeps the existing result encoding (bit 7 = valid, low bits = port index).

## Interface
- PORT_NUM, 10, number of requesting FIFOs; legal range 2..128.
- IDX_W, 7, index field width; PORT_NUM must be ≤ 2^IDX_W; IDX_W ≤ 7.
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.
- CNT_W, 8, hold counter width; requires MAX_HOLD < 2^CNT_W.
- glb_clk, in, 1, single clock; all logic rises on the posedge.
- glb_areset_n, in, 1, asynchronous active-low reset.
- fifo_sel_bits, in, PORT_NUM, per-port request (FIFO has data).
- rr_mode, in, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- sel_done, in, 1, consumer pulse that releases the current grant.
- fifo_sel_res_final, out, 8, grant result: {1'b1, zero-extended index} (128+idx) when granted, 8'd0 otherwise.
- fifo_grant_onehot, out, PORT_NUM, one-hot grant; all zeros when idle.
- sel_timeout, out, 1, one-cycle pulse when a grant is ended by timeout.

## Operation
- There are two states, IDLE and HOLD. All outputs are registered.
- **Reset values:**
  - state = IDLE.
  - fifo_sel_res_final = 0.
  - fifo_grant_onehot = 0.
  - sel_timeout = 0.
  - hold_cnt = 0.
  - last_grant = PORT_NUM-1, so the first round-robin winner is port 0.
- **IDLE:**
  - If fifo_sel_bits == 0, stay in IDLE with outputs at 0.
  - Otherwise compute the winner:
    - rr_mode = 0: lowest set index.
    - rr_mode = 1: first set index scanning last_grant+1, last_grant+2, …, wrapping from PORT_NUM-1 to 0, with last_grant scanned last.
  - Register the winner into fifo_sel_res_final and fifo_grant_onehot, clear hold_cnt, and go to HOLD.
  - sel_done is ignored in IDLE.
- **HOLD:**
  - The grant is frozen. Changes to other request bits and to rr_mode have no effect.
  - Release conditions, evaluated every cycle:
    - (a) sel_done = 1;
    - (b) fifo_sel_bits[cur] = 0;
    - (c) MAX_HOLD ≠ 0 and hold_cnt == MAX_HOLD-1.
  - On release:
    - go to IDLE;
    - set outputs to 0;
    - set last_grant = cur (updated in both modes).
  - Otherwise hold_cnt increments, saturating at 2^CNT_W - 1.
- **sel_timeout:**
  - Asserts for exactly the cycle after a release caused by (c) alone.
  - If (c) coincides with (a) or (b), the release counts as normal and sel_timeout stays 0.
- **Back-to-back grants:** IDLE always lasts at least one cycle between grants. This guarantees a one-cycle 8'd0 gap on fifo_sel_res_final, so downstream logic can detect grant edges.
- **Width rule:** the output is 8 bits regardless of PORT_NUM. The index is zero-extended to 7 bits and bit 7 is the valid bit.

## Timing
- Request to grant latency is 1 cycle. A request sampled at edge N in IDLE gives a valid output in cycle N+1.
- Release to output 0 latency is 1 cycle. The earliest next grant is 2 cycles after the release edge.
- Maximum grant duration is exactly MAX_HOLD cycles when MAX_HOLD ≠ 0.
- Grant throughput under continuous requests: one grant per (hold length + 1) cycles.
- Asynchronous reset clears all state immediately, including mid-HOLD. Arbitration resumes on the first clock edge after deassertion, with last_grant = PORT_NUM-1.

## Test plan
All tests use PORT_NUM=10 and MAX_HOLD=16.

- **Reset:** assert glb_areset_n=0 with fifo_sel_bits=10'h3FF → fifo_sel_res_final=8'h00, onehot=0, sel_timeout=0. Release reset → 8'h80 one cycle later.
- **Fixed priority and hold:**
  - rr_mode=0, fifo_sel_bits=10'h004 → 8'h82 next cycle.
  - Raise bit 0 while bit 2 is still high → output stays 8'h82.
  - Drop bit 2 → 8'h00 for one cycle, then 8'h80.
- **Round-robin rotation:** rr_mode=1, fifo_sel_bits=10'h3FF, sel_done pulsed one cycle after each grant → grants 8'h80, 8'h81, …, 8'h89, then 8'h80 (wrap), each separated by one 8'h00 cycle.
- **Timeout:**
  - fifo_sel_bits=10'h020 held, no sel_done → 8'h85 for exactly 16 cycles, then 8'h00 with sel_timeout=1 for one cycle.
  - Next cycle → 8'h85 again.
- **Simultaneous release:**
  - sel_done asserted on the hold cycle where hold_cnt=15 → release with sel_timeout=0.
  - Separately: sel_done and the request drop in the same cycle → a single release and a single 8'h00 gap.
- **Reset mid-HOLD:**
  - rr_mode=1, grant 8'h83 active, assert reset → outputs 0 immediately.
  - After reset, with requests 10'h00C → 8'h82 (scan restarts at port 0, not port 4).
